// File: rtl/axis_adc_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// axis_adc_trigger_sequencer
//
// Purpose:
//    Arms on a start pulse, discards a programmable number of ADC samples
//    (holdoff), waits for a trigger (external edge, channel-A level crossing
//    rising/falling, or immediate), then forwards a programmable number of
//    samples to an AXI-Stream master through a one-deep output register.
//    Samples that arrive while the output word is still unaccepted are
//    dropped, counted, and flagged through a sticky overflow bit.
//
// Ports:
//    aclk, aresetn        clock, asynchronous active-low reset
//    cfg_holdoff          samples discarded after arm
//    cfg_length           samples captured per trigger (0 = no capture)
//    cfg_level            signed threshold on channel A (tdata[15:0])
//    cfg_trig_sel         0 external, 1 rising, 2 falling, 3 immediate
//    start, abort         single-cycle arm / cancel requests
//    trg_flag             external trigger level, synchronous to aclk
//    s_axis_*             ADC sample stream (never stalled)
//    m_axis_*             captured sample stream
//    sts_count            samples consumed in the current capture
//    busy, done, overflow status flags
// -----------------------------------------------------------------------------
module axis_adc_trigger_sequencer #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
   input  logic [CNTR_WIDTH-1:0]       cfg_length,
   input  logic [15:0]                 cfg_level,
   input  logic [1:0]                  cfg_trig_sel,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        trg_flag,
   input  logic                        s_axis_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   output logic                        s_axis_tready,
   output logic                        m_axis_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
   output logic [CNTR_WIDTH-1:0]       sts_count,
   output logic                        busy,
   output logic                        done,
   output logic                        overflow
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HOLDOFF = 3'd1;
   localparam logic [2:0] ST_ARMED   = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [1:0] SEL_EXT  = 2'd0;
   localparam logic [1:0] SEL_RISE = 2'd1;
   localparam logic [1:0] SEL_FALL = 2'd2;
   localparam logic [1:0] SEL_IMM  = 2'd3;

   localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
   localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNTR_WIDTH-1:0] sat_inc(input logic [CNTR_WIDTH-1:0] v);
      logic [CNTR_WIDTH-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   // state and latched configuration
   logic [2:0]                  state_q,    state_d;
   logic [CNTR_WIDTH-1:0]       holdoff_q,  holdoff_d;
   logic [CNTR_WIDTH-1:0]       length_q,   length_d;
   logic signed [15:0]          level_q,    level_d;
   logic [1:0]                  sel_q,      sel_d;

   // counters and history
   logic [CNTR_WIDTH-1:0]       hold_cnt_q, hold_cnt_d;
   logic [CNTR_WIDTH-1:0]       count_q,    count_d;
   logic signed [15:0]          prev_q,     prev_d;
   logic                        trg_prev_q, trg_prev_d;

   // output register and status
   logic                        tvalid_q,   tvalid_d;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q,    tdata_d;
   logic                        tlast_q,    tlast_d;
   logic                        overflow_q, overflow_d;
   logic                        done_q,     done_d;
   logic                        busy_q,     busy_d;

   // decoded helpers
   logic signed [15:0]          cha_s;
   logic                        start_s;
   logic                        rise_s;
   logic                        fall_s;
   logic                        ext_s;
   logic                        trig_cond_s;
   logic                        fire_s;
   logic                        capture_s;
   logic                        last_s;
   logic                        out_free_s;
   logic [CNTR_WIDTH-1:0]       cnt_inc_s;
   logic [CNTR_WIDTH-1:0]       hold_inc_s;

   assign cha_s      = $signed(s_axis_tdata[15:0]);
   // abort takes priority over a simultaneous start
   assign start_s    = start && !abort;
   assign rise_s     = (prev_q < level_q) && (level_q <= cha_s);
   assign fall_s     = (prev_q > level_q) && (level_q >= cha_s);
   assign ext_s      = trg_flag && !trg_prev_q;
   // the output register can take a new word if empty or being drained now
   assign out_free_s = !tvalid_q || m_axis_tready;
   assign cnt_inc_s  = sat_inc(count_q);
   assign hold_inc_s = sat_inc(hold_cnt_q);

   // Trigger condition selected by the latched trigger mode.
   always_comb begin
      trig_cond_s = 1'b0;
      case (sel_q)
         SEL_EXT:  trig_cond_s = ext_s;
         SEL_RISE: trig_cond_s = rise_s;
         SEL_FALL: trig_cond_s = fall_s;
         SEL_IMM:  trig_cond_s = 1'b1;
         default:  trig_cond_s = 1'b0;
      endcase
   end

   assign fire_s    = s_axis_tvalid && (state_q == ST_ARMED) && trig_cond_s;
   // the triggering sample is itself the first captured sample
   assign capture_s = s_axis_tvalid && !abort &&
                      ((state_q == ST_CAPTURE) || (fire_s && (length_q != CNT_ZERO)));
   assign last_s    = (cnt_inc_s >= length_q);

   // Next-state logic for the sequencer, output register and status.
   always_comb begin
      state_d    = state_q;
      holdoff_d  = holdoff_q;
      length_d   = length_q;
      level_d    = level_q;
      sel_d      = sel_q;
      hold_cnt_d = hold_cnt_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      tdata_d    = tdata_q;
      trg_prev_d = trg_flag;

      // channel-A history tracks every valid sample regardless of state
      if (s_axis_tvalid) begin
         prev_d = cha_s;
      end else begin
         prev_d = prev_q;
      end

      if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end else begin
         tvalid_d = tvalid_q;
         tlast_d  = tlast_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_s) begin
               holdoff_d  = cfg_holdoff;
               length_d   = cfg_length;
               level_d    = $signed(cfg_level);
               sel_d      = cfg_trig_sel;
               hold_cnt_d = CNT_ZERO;
               count_d    = CNT_ZERO;
               overflow_d = 1'b0;
               state_d    = (cfg_holdoff == CNT_ZERO) ? ST_ARMED : ST_HOLDOFF;
            end else begin
               state_d = state_q;
            end
         end
         ST_HOLDOFF: begin
            if (s_axis_tvalid) begin
               hold_cnt_d = hold_inc_s;
               if (hold_inc_s >= holdoff_q) begin
                  state_d = ST_ARMED;
               end else begin
                  state_d = ST_HOLDOFF;
               end
            end else begin
               state_d = ST_HOLDOFF;
            end
         end
         ST_ARMED: begin
            // a zero-length capture completes on the trigger with no output
            if (fire_s && (length_q == CNT_ZERO)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_CAPTURE: begin
            state_d = ST_CAPTURE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture_s) begin
         count_d = cnt_inc_s;
         if (out_free_s) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_tdata;
            tlast_d  = last_s;
         end else begin
            overflow_d = 1'b1;
            // final sample lost: close the packet on the word still pending
            if (last_s) begin
               tlast_d = 1'b1;
            end else begin
               tlast_d = tlast_q;
            end
         end
         state_d = last_s ? ST_DONE : ST_CAPTURE;
      end else begin
         count_d = count_d;
      end

      if (abort) begin
         state_d  = ST_IDLE;
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end else begin
         state_d = state_d;
      end

      busy_d = (state_d == ST_HOLDOFF) || (state_d == ST_ARMED) ||
               (state_d == ST_CAPTURE) || tvalid_d;
      done_d = (state_d == ST_DONE);
   end

   // State, configuration, counters and registered outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         holdoff_q  <= CNT_ZERO;
         length_q   <= CNT_ZERO;
         level_q    <= 16'sd0;
         sel_q      <= 2'd0;
         hold_cnt_q <= CNT_ZERO;
         count_q    <= CNT_ZERO;
         prev_q     <= 16'sd0;
         trg_prev_q <= 1'b0;
         tvalid_q   <= 1'b0;
         tdata_q    <= {AXIS_TDATA_WIDTH{1'b0}};
         tlast_q    <= 1'b0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         holdoff_q  <= holdoff_d;
         length_q   <= length_d;
         level_q    <= level_d;
         sel_q      <= sel_d;
         hold_cnt_q <= hold_cnt_d;
         count_q    <= count_d;
         prev_q     <= prev_d;
         trg_prev_q <= trg_prev_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tlast_q    <= tlast_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign s_axis_tready = 1'b1;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign sts_count     = count_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign overflow      = overflow_q;

endmodule

// File: doc/axis_adc_trigger_sequencer.md
AXIS_ADC_TRIGGER_SEQUENCER -- requirements
Module: axis_adc_trigger_sequencer

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32: ADC stream width; channel A in [15:0], channel B in [31:16], both sign-extended two's complement.
REQ-002 Parameter CNTR_WIDTH, default 32: width of holdoff, length and status counters.
REQ-003 Port aclk, in, 1: sole clock; all logic rising-edge.
REQ-004 Port aresetn, in, 1: asynchronous active-low reset.
REQ-005 Port cfg_holdoff, in, CNTR_WIDTH: samples discarded after arm before triggers are accepted.
REQ-006 Port cfg_length, in, CNTR_WIDTH: samples captured per trigger.
REQ-007 Port cfg_level, in, 16: signed trigger threshold on channel A.
REQ-008 Port cfg_trig_sel, in, 2: 0 external, 1 level rising, 2 level falling, 3 immediate.
REQ-009 Port start, in, 1: single-cycle arm request.
REQ-010 Port abort, in, 1: single-cycle cancel.
REQ-011 Port trg_flag, in, 1: external trigger, synchronous to aclk.
REQ-012 Port s_axis_tvalid / s_axis_tdata, in, 1 / AXIS_TDATA_WIDTH: ADC sample stream.
REQ-013 Port s_axis_tready, out, 1: constant 1; the ADC is never stalled.
REQ-014 Port m_axis_tvalid / m_axis_tdata / m_axis_tlast, out, 1 / AXIS_TDATA_WIDTH / 1; m_axis_tready, in, 1: captured stream.
REQ-015 Port sts_count, out, CNTR_WIDTH: samples consumed in current capture.
REQ-016 Port busy / done / overflow, out, 1 each: status flags.

Function
REQ-017 FSM states SHALL be IDLE, HOLDOFF, ARMED, CAPTURE, DONE.
REQ-018 start in IDLE or DONE SHALL latch all cfg_* inputs, clear sts_count, done and overflow, and enter HOLDOFF next cycle (ARMED if cfg_holdoff=0); start is ignored in other states.
REQ-019 HOLDOFF SHALL count valid input samples and enter ARMED in the cycle after the cfg_holdoff-th sample.
REQ-020 Level trigger SHALL fire on a valid sample when previous valid channel-A sample < level <= current (rising) or previous > level >= current (falling); previous-sample register updates on every valid sample in all states.
REQ-021 External trigger SHALL fire on a valid sample in ARMED while trg_flag=1 and trg_flag was 0 the previous cycle; select 3 fires on the first valid sample in ARMED.
REQ-022 The triggering sample SHALL be the first captured sample; FSM enters CAPTURE on that edge.
REQ-023 Each captured sample SHALL appear on m_axis_tdata with m_axis_tvalid one cycle after acceptance (one-deep output register); tvalid held until m_axis_tready.
REQ-024 If a captured sample arrives while the output register holds an unaccepted word, the new sample SHALL be dropped, overflow set (sticky), and the sample still counted in sts_count.
REQ-025 m_axis_tlast SHALL accompany the sample whose count equals cfg_length; FSM enters DONE when that sample is consumed or dropped.
REQ-026 cfg_length=0 SHALL enter DONE on the trigger edge with no output words.
REQ-027 DONE SHALL assert done=1 until next start; busy=1 in HOLDOFF, ARMED, CAPTURE, and while an output word is pending.
REQ-028 abort in any state SHALL return to IDLE next cycle, clear m_axis_tvalid, keep sts_count and overflow; abort wins over simultaneous start.
REQ-029 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-030 aresetn=0 SHALL immediately force IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_count=0, busy=0, done=0, overflow=0, previous-sample register=0.
REQ-031 Reset mid-capture SHALL discard the pending output word; first start after release behaves as REQ-018.

Verification
REQ-032 holdoff=4, length=8, sel=3, tready=1, ramp input -> 4 samples discarded, 8 words out, tlast on 8th, done=1, overflow=0.
REQ-033 sel=1, level=100, channel A 90,95,105 -> capture begins with 105; sel=2 on same data never fires.
REQ-034 length=16, tready low 3 cycles mid-capture -> overflow=1, sts_count=16, fewer than 16 words, tlast on final word emitted.
REQ-035 abort during ARMED and simultaneous start+abort -> IDLE, busy=0, no output words.
REQ-036 length=0, sel=0, trg_flag rising -> DONE with zero words; aresetn pulse during CAPTURE -> all outputs 0 at once.
